l2_tag_lat_monitor: RTL and testbench

L2_TAG_LAT_MONITOR -- requirements
Module: l2_tag_lat_monitor

---
 rtl/l2_tag_mon_pkg.sv | 26 ++
 rtl/lat_mon_chan.sv | 82 ++++++++
 rtl/l2_tag_lat_monitor.sv | 98 +++++++++
 tb/tb_l2_tag_lat_monitor.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_tag_mon_pkg.sv
// Shared types and defaults for the L2 tag latency monitor.
// Per-entry ages are stored in a fixed-width lat_t and saturate at the instance's LAT_W limit.
package l2_tag_mon_pkg;

    localparam int LAT_MAX_W         = 16;
    localparam int MAX_LAT_NORM_DEF  = 5;
    localparam int MAX_LAT_FLUSH_DEF = 7;

    typedef logic [LAT_MAX_W-1:0] lat_t;

    typedef struct packed {
        lat_t age;
        logic mode;
        logic flagged;
    } entry_t;

    function automatic lat_t age_inc(lat_t age, lat_t age_max);
        return (age >= age_max) ? age_max : age + lat_t'(1);
    endfunction

    // True when popping this entry now would give a latency above its bound.
    function automatic logic lat_exceeds(lat_t age, logic mode, int norm_bound, int flush_bound);
        return (int'(age) + 1) > (mode ? flush_bound : norm_bound);
    endfunction

endpackage

// File: rtl/lat_mon_chan.sv
// One channel of the latency monitor: in-order outstanding queue (head at index 0),
// per-entry ages and single-cycle error/pop pulses for the top to aggregate.
module lat_mon_chan
    import l2_tag_mon_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int LAT_W         = 8,
    parameter int MAX_LAT_NORM  = MAX_LAT_NORM_DEF,
    parameter int MAX_LAT_FLUSH = MAX_LAT_FLUSH_DEF,
    parameter int CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_fire,
    input  logic             rsp_fire,
    input  logic             flush_active,
    output logic [CNT_W-1:0] outstanding,
    output logic             lat_evt,
    output logic [CNT_W-1:0] lat_evt_cnt,
    output logic             orphan_evt,
    output logic             overflow_evt,
    output logic             pop_vld,
    output logic [LAT_W-1:0] pop_lat
);

    localparam lat_t AGE_MAX = lat_t'((1 << LAT_W) - 1);

    entry_t           q    [DEPTH];
    entry_t           q_n  [DEPTH];
    entry_t           aged [DEPTH+1];
    logic [DEPTH-1:0] hit;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] wr_idx;
    logic             full;
    logic             push;

    assign outstanding = cnt;

    always_comb begin
        full         = (cnt == CNT_W'(DEPTH));
        pop_vld      = rsp_fire && (cnt != '0);
        orphan_evt   = rsp_fire && (cnt == '0);
        push         = req_fire && (!full || pop_vld);
        overflow_evt = req_fire && full && !pop_vld;
        pop_lat      = LAT_W'(age_inc(q[0].age, AGE_MAX));

        // A popped head that has overrun its bound is still counted: it leaves
        // the queue this cycle, so it can never be counted twice.
        lat_evt_cnt  = '0;
        aged[DEPTH]  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = (CNT_W'(i) < cnt) && !q[i].flagged &&
                     lat_exceeds(q[i].age, q[i].mode, MAX_LAT_NORM, MAX_LAT_FLUSH);
            lat_evt_cnt     = lat_evt_cnt + CNT_W'(hit[i]);
            aged[i]         = q[i];
            aged[i].age     = age_inc(q[i].age, AGE_MAX);
            aged[i].flagged = q[i].flagged | hit[i];
        end
        lat_evt = |hit;

        wr_idx = pop_vld ? cnt - CNT_W'(1) : cnt;
        cnt_n  = cnt + CNT_W'(push) - CNT_W'(pop_vld);
        for (int i = 0; i < DEPTH; i++) begin
            q_n[i] = pop_vld ? aged[i+1] : aged[i];
            if (push && (wr_idx == CNT_W'(i))) begin
                q_n[i] = '{age: '0, mode: flush_active, flagged: 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            cnt <= cnt_n;
            for (int i = 0; i < DEPTH; i++) q[i] <= q_n[i];
        end
    end

endmodule

// File: rtl/l2_tag_lat_monitor.sv
// Multi-channel L2 tag request/response latency monitor: NUM_CH independent
// channel trackers, sticky per-channel errors, global violation count and max latency.
module l2_tag_lat_monitor
    import l2_tag_mon_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int DEPTH         = 4,
    parameter int LAT_W         = 8,
    parameter int MAX_LAT_NORM  = MAX_LAT_NORM_DEF,
    parameter int MAX_LAT_FLUSH = MAX_LAT_FLUSH_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_CH-1:0]                    req_valid,
    input  logic [NUM_CH-1:0]                    req_ready,
    input  logic [NUM_CH-1:0]                    rsp_valid,
    input  logic [NUM_CH-1:0]                    rsp_ready,
    input  logic                                 flush_active,
    input  logic                                 clear,
    output logic [NUM_CH-1:0]                    err_latency,
    output logic [NUM_CH-1:0]                    err_orphan,
    output logic [NUM_CH-1:0]                    err_overflow,
    output logic [NUM_CH*$clog2(DEPTH+1)-1:0]    outstanding,
    output logic [15:0]                          violation_cnt,
    output logic [LAT_W-1:0]                     max_lat_seen
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [NUM_CH-1:0]            lat_evt;
    logic [NUM_CH-1:0]            orphan_evt;
    logic [NUM_CH-1:0]            overflow_evt;
    logic [NUM_CH-1:0]            pop_vld;
    logic [NUM_CH-1:0][CNT_W-1:0] lat_evt_cnt;
    logic [NUM_CH-1:0][LAT_W-1:0] pop_lat;

    int                           evt_sum;
    int                           viol_sum;
    logic [15:0]                  viol_n;
    logic [LAT_W-1:0]             max_n;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        lat_mon_chan #(
            .DEPTH         (DEPTH),
            .LAT_W         (LAT_W),
            .MAX_LAT_NORM  (MAX_LAT_NORM),
            .MAX_LAT_FLUSH (MAX_LAT_FLUSH),
            .CNT_W         (CNT_W)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .req_fire     (req_valid[ch] & req_ready[ch]),
            .rsp_fire     (rsp_valid[ch] & rsp_ready[ch]),
            .flush_active (flush_active),
            .outstanding  (outstanding[ch*CNT_W +: CNT_W]),
            .lat_evt      (lat_evt[ch]),
            .lat_evt_cnt  (lat_evt_cnt[ch]),
            .orphan_evt   (orphan_evt[ch]),
            .overflow_evt (overflow_evt[ch]),
            .pop_vld      (pop_vld[ch]),
            .pop_lat      (pop_lat[ch])
        );
    end

    always_comb begin
        evt_sum = 0;
        max_n   = max_lat_seen;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            evt_sum = evt_sum + int'(lat_evt_cnt[ch]) + int'(orphan_evt[ch]) + int'(overflow_evt[ch]);
            if (pop_vld[ch] && (pop_lat[ch] > max_n)) max_n = pop_lat[ch];
        end
        viol_sum = int'(violation_cnt) + evt_sum;
        viol_n   = (viol_sum > 65535) ? 16'hFFFF : 16'(viol_sum);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_latency   <= '0;
            err_orphan    <= '0;
            err_overflow  <= '0;
            violation_cnt <= '0;
            max_lat_seen  <= '0;
        end else if (clear) begin
            err_latency   <= '0;
            err_orphan    <= '0;
            err_overflow  <= '0;
            violation_cnt <= '0;
            max_lat_seen  <= '0;
        end else begin
            err_latency   <= err_latency  | lat_evt;
            err_orphan    <= err_orphan   | orphan_evt;
            err_overflow  <= err_overflow | overflow_evt;
            violation_cnt <= viol_n;
            max_lat_seen  <= max_n;
        end
    end

endmodule

// File: tb/tb_l2_tag_lat_monitor.sv
// Bench for l2_tag_lat_monitor: directed scenarios plus randomized traffic, all checked
// against a cycle-stamped queue model (latency = response cycle - request cycle).
module tb_l2_tag_lat_monitor;

    localparam int NUM_CH = 2;
    localparam int DEPTH  = 4;
    localparam int LAT_W  = 8;
    localparam int NORM   = 5;
    localparam int FLUSH  = 7;
    localparam int CW     = $clog2(DEPTH + 1);

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NUM_CH-1:0]      req_valid = '0;
    logic [NUM_CH-1:0]      req_ready = '0;
    logic [NUM_CH-1:0]      rsp_valid = '0;
    logic [NUM_CH-1:0]      rsp_ready = '0;
    logic                   flush_active = 1'b0;
    logic                   clear = 1'b0;
    logic [NUM_CH-1:0]      err_latency;
    logic [NUM_CH-1:0]      err_orphan;
    logic [NUM_CH-1:0]      err_overflow;
    logic [NUM_CH*CW-1:0]   outstanding;
    logic [15:0]            violation_cnt;
    logic [LAT_W-1:0]       max_lat_seen;

    always #5 clk = ~clk;

    l2_tag_lat_monitor #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .LAT_W(LAT_W),
        .MAX_LAT_NORM(NORM), .MAX_LAT_FLUSH(FLUSH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .flush_active(flush_active), .clear(clear),
        .err_latency(err_latency), .err_orphan(err_orphan), .err_overflow(err_overflow),
        .outstanding(outstanding), .violation_cnt(violation_cnt), .max_lat_seen(max_lat_seen)
    );

    // Reference model: each outstanding request remembers the cycle it was accepted in.
    typedef struct {
        int born;
        bit mode;
        bit counted;
    } ment_t;

    ment_t             mq [NUM_CH][$];
    int                cyc;
    bit [NUM_CH-1:0]   m_el, m_eo, m_eov;
    int                m_viol, m_max;
    int                n_chk, n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) mq[ch].delete();
        m_el = '0; m_eo = '0; m_eov = '0; m_viol = 0; m_max = 0;
    endtask

    task automatic model_step(input bit [NUM_CH-1:0] rv, rr, sv, sr, input bit fl, clr);
        int              ev;
        int              mx;
        bit [NUM_CH-1:0] el, eo, eov;
        ev = 0; mx = m_max; el = '0; eo = '0; eov = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            int n0;
            bit popped;
            n0 = mq[ch].size();
            popped = 0;
            for (int k = 0; k < n0; k++) begin
                ment_t e;
                int    bnd;
                e = mq[ch][k];
                bnd = e.mode ? FLUSH : NORM;
                if (!e.counted && (cyc - e.born > bnd)) begin
                    e.counted = 1;
                    mq[ch][k] = e;
                    ev++;
                    el[ch] = 1;
                end
            end
            if (sv[ch] && sr[ch]) begin
                if (n0 == 0) begin
                    eo[ch] = 1;
                    ev++;
                end else begin
                    ment_t h;
                    int    l;
                    h = mq[ch].pop_front();
                    l = cyc - h.born;
                    if (l > 255) l = 255;
                    if (l > mx) mx = l;
                    popped = 1;
                end
            end
            if (rv[ch] && rr[ch]) begin
                if (n0 == DEPTH && !popped) begin
                    eov[ch] = 1;
                    ev++;
                end else begin
                    ment_t nw;
                    nw.born = cyc; nw.mode = fl; nw.counted = 0;
                    mq[ch].push_back(nw);
                end
            end
        end
        if (clr) begin
            m_el = '0; m_eo = '0; m_eov = '0; m_viol = 0; m_max = 0;
        end else begin
            m_el |= el; m_eo |= eo; m_eov |= eov;
            m_viol = (m_viol + ev > 65535) ? 65535 : m_viol + ev;
            m_max = mx;
        end
        cyc++;
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".err_lat"},  32'(err_latency),   32'(m_el));
        chk({ph, ".err_orph"}, 32'(err_orphan),    32'(m_eo));
        chk({ph, ".err_ovf"},  32'(err_overflow),  32'(m_eov));
        chk({ph, ".viol"},     32'(violation_cnt), m_viol);
        chk({ph, ".maxlat"},   32'(max_lat_seen),  m_max);
        for (int ch = 0; ch < NUM_CH; ch++)
            chk($sformatf("%s.out%0d", ph, ch), 32'(outstanding[ch*CW +: CW]), mq[ch].size());
    endtask

    // Called at a negedge: apply inputs, advance the model, check after the next posedge.
    task automatic step(input string ph, input bit [NUM_CH-1:0] rv, rr, sv, sr, input bit fl, clr);
        req_valid = rv; req_ready = rr; rsp_valid = sv; rsp_ready = sr;
        flush_active = fl; clear = clr;
        model_step(rv, rr, sv, sr, fl, clr);
        @(negedge clk);
        check_all(ph);
    endtask

    task automatic idle(input string ph, input int n);
        repeat (n) step(ph, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string ph);
        req_valid = '0; req_ready = '0; rsp_valid = '0; rsp_ready = '0;
        flush_active = 1'b0; clear = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(ph);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // single normal request, response at latency 5
        step("d36", 2'b01, 2'b01, '0, '0, 1'b0, 1'b0);
        idle("d36", 4);
        step("d36", '0, '0, 2'b01, 2'b01, 1'b0, 1'b0);
        chk("d36.max5", 32'(max_lat_seen), 5);
        chk("d36.noerr", 32'(err_latency), 0);

        // normal request left 6 cycles: one latency violation, response adds nothing
        step("d37", 2'b01, 2'b01, '0, '0, 1'b0, 1'b0);
        idle("d37", 6);
        chk("d37.errlat", 32'(err_latency[0]), 1);
        chk("d37.viol1", 32'(violation_cnt), 1);
        step("d37", '0, '0, 2'b01, 2'b01, 1'b0, 1'b0);
        chk("d37.viol_still1", 32'(violation_cnt), 1);
        step("d37", '0, '0, '0, '0, 1'b0, 1'b1);

        // flush requests: latency 7 is fine, latency 8 violates
        step("d38", 2'b01, 2'b01, '0, '0, 1'b1, 1'b0);
        idle("d38", 6);
        step("d38", '0, '0, 2'b01, 2'b01, 1'b0, 1'b0);
        chk("d38.lat7_ok", 32'(err_latency[0]), 0);
        chk("d38.max7", 32'(max_lat_seen), 7);
        step("d38", 2'b01, 2'b01, '0, '0, 1'b1, 1'b0);
        idle("d38", 7);
        step("d38", '0, '0, 2'b01, 2'b01, 1'b0, 1'b0);
        chk("d38.lat8_err", 32'(err_latency[0]), 1);
        step("d38", '0, '0, '0, '0, 1'b0, 1'b1);

        // overflow on ch1, then a push with simultaneous pop at full
        repeat (5) step("d39", 2'b10, 2'b10, '0, '0, 1'b0, 1'b0);
        chk("d39.ovf", 32'(err_overflow[1]), 1);
        chk("d39.out4", 32'(outstanding[CW +: CW]), 4);
        step("d39", '0, '0, '0, '0, 1'b0, 1'b1);
        step("d39", 2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0);
        chk("d39.full_pushpop_ok", 32'(err_overflow[1]), 0);
        chk("d39.out_still4", 32'(outstanding[CW +: CW]), 4);
        repeat (4) step("d39", '0, '0, 2'b10, 2'b10, 1'b0, 1'b0);
        step("d39", '0, '0, '0, '0, 1'b0, 1'b1);

        // response on empty ch0 together with a request
        step("d40", 2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0);
        chk("d40.orphan", 32'(err_orphan[0]), 1);
        chk("d40.out1", 32'(outstanding[0 +: CW]), 1);
        step("d40", '0, '0, 2'b01, 2'b01, 1'b0, 1'b0);
        step("d40", '0, '0, '0, '0, 1'b0, 1'b1);

        // reset with 3 outstanding, then a response is an orphan
        repeat (3) step("d41", 2'b01, 2'b01, '0, '0, 1'b0, 1'b0);
        do_reset("d41.rst");
        chk("d41.out0", 32'(outstanding), 0);
        step("d41", '0, '0, 2'b01, 2'b01, 1'b0, 1'b0);
        chk("d41.orphan", 32'(err_orphan[0]), 1);
        chk("d41.viol1", 32'(violation_cnt), 1);

        // randomized traffic at several load levels
        for (int ph = 0; ph < 4; ph++) begin
            int p_req, p_rsp;
            p_req = 20 + ph * 20;
            p_rsp = 15 + ph * 20;
            for (int c = 0; c < 600; c++) begin
                bit [NUM_CH-1:0] rv, rr, sv, sr;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    rv[ch] = ($urandom_range(99) < p_req);
                    rr[ch] = ($urandom_range(99) < 80);
                    sv[ch] = ($urandom_range(99) < p_rsp);
                    sr[ch] = ($urandom_range(99) < 80);
                end
                if ($urandom_range(999) < 2) do_reset("rnd.rst");
                else step("rnd", rv, rr, sv, sr, 1'($urandom_range(99) < 30),
                          1'($urandom_range(99) < 2));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
